hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: D-stage interlock and forwarding select over NSTAGE tracked stages, plus MDU busy interlock.
// Build option HAZARD_FWD_EN enables forwarding; without it any in-flight matching producer stalls D.
module hazard_unit #(
   parameter int NSTAGE   = 3,
   parameter int REG_W    = 5,
   parameter int T_W      = 4,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] rs_d,
   input  logic [REG_W-1:0] rt_d,
   input  logic [T_W-1:0]   t_rs_d,
   input  logic [T_W-1:0]   t_rt_d,
   input  logic [REG_W-1:0] dst_d,
   input  logic [T_W-1:0]   t_d,
   input  logic             start_d,
   input  logic             is_div_d,
   input  logic             mdu_acc_d,
   input  logic             flush,
   output logic             stall,
   output logic [T_W-1:0]   fwd_rs,
   output logic [T_W-1:0]   fwd_rt,
   output logic             mdu_busy
);

   localparam logic [T_W-1:0] T_NONE  = '1;
   localparam int             MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
   localparam int             CNT_W   = $clog2(MAX_LAT + 1);

   logic [REG_W-1:0] dst_q [1:NSTAGE];
   logic [T_W-1:0]   t_q   [1:NSTAGE];
   logic [CNT_W-1:0] mdu_cnt;
   logic [NSTAGE:1]  live;
   logic [REG_W-1:0] src_addr [2];
   logic [T_W-1:0]   src_use  [2];
   logic [T_W-1:0]   fwd      [2];
   logic             haz_stall;
   logic             found;

   assign src_addr[0] = rs_d;
   assign src_addr[1] = rt_d;
   assign src_use[0]  = t_rs_d;
   assign src_use[1]  = t_rt_d;

   always_comb begin
      live = '0;
      for (int s = 1; s <= NSTAGE; s++) begin
         live[s] = (dst_q[s] != '0) && (t_q[s] != T_NONE);
      end
   end

`ifdef HAZARD_FWD_EN
   logic [T_W-1:0] rem [1:NSTAGE];

   always_comb begin
      for (int s = 1; s <= NSTAGE; s++) begin
         rem[s] = (t_q[s] > T_W'(s)) ? (t_q[s] - T_W'(s)) : '0;
      end
   end
`endif

   // Only the nearest matching producer counts; an older copy of the register is stale.
   always_comb begin
      haz_stall = 1'b0;
      found     = 1'b0;
      fwd[0]    = '0;
      fwd[1]    = '0;
      for (int i = 0; i < 2; i++) begin
         found = 1'b0;
         if ((src_use[i] != T_NONE) && (src_addr[i] != '0)) begin
            for (int s = 1; s <= NSTAGE; s++) begin
               if (!found && live[s] && (dst_q[s] == src_addr[i])) begin
                  found = 1'b1;
`ifdef HAZARD_FWD_EN
                  if (rem[s] > src_use[i]) begin
                     haz_stall = 1'b1;
                  end else if (rem[s] == '0) begin
                     fwd[i] = T_W'(s);
                  end
`else
                  haz_stall = 1'b1;
`endif
               end
            end
         end
      end
   end

   assign mdu_busy = (mdu_cnt != '0);
   assign stall    = haz_stall || ((start_d || mdu_acc_d) && mdu_busy);
   assign fwd_rs   = fwd[0];
   assign fwd_rt   = fwd[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 1; s <= NSTAGE; s++) begin
            dst_q[s] <= '0;
            t_q[s]   <= T_NONE;
         end
         mdu_cnt <= '0;
      end else begin
         if (flush || stall) begin
            dst_q[1] <= '0;
            t_q[1]   <= T_NONE;
         end else begin
            dst_q[1] <= dst_d;
            t_q[1]   <= t_d;
         end
         for (int s = 2; s <= NSTAGE; s++) begin
            if (flush) begin
               dst_q[s] <= '0;
               t_q[s]   <= T_NONE;
            end else begin
               dst_q[s] <= dst_q[s-1];
               t_q[s]   <= t_q[s-1];
            end
         end
         // Flush squashes the pipeline but an issued MDU operation keeps running.
         if (start_d && !stall) begin
            mdu_cnt <= is_div_d ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
         end else if (mdu_cnt != '0) begin
            mdu_cnt <= mdu_cnt - CNT_W'(1);
         end
      end
   end

endmodule
